// File: rtl/ecc_apb_monitor.sv
// ecc_apb_monitor
//
// Purpose: passive protocol and result checker that sits beside the APB-driven
// ECC encoder/decoder and its golden model. It watches the APB bus, the DUT
// result outputs and the golden-model outputs. It records every detected
// problem in three places:
//   - a sticky flag per check,
//   - a saturating failure counter,
//   - a one-shot first-failure capture that carries a free-running cycle stamp.
//
// Check codes (bit i of chk_en / err_sticky):
//   0 RST      DUT outputs nonzero on the first edge after reset release
//   1 READ     APB read data differs from golden-model register read
//   2 EARLY    operation_done rose before MIN_LAT cycles after a control write
//   3 TIMEOUT  operation_done absent MAX_LAT cycles after a control write
//   4 RESULT   data_out differs from golden data on a completed operation
//   5 NOE      error count differs from golden count (non-zero mode only)
//   6 BOUND    num_of_errors reports the illegal value 3 while done is high
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   PADDR, PWDATA, PENABLE, PSEL,  observed APB request
//   PWRITE
//   PRDATA                         DUT read data
//   registers_out                  golden-model read data
//   data_out, operation_done,      DUT result, done and error count
//   num_of_errors
//   gm_data_out,                   golden-model result and error count
//   gm_number_of_errors
//   chk_en                         runtime enable per check code
//   err_sticky                     sticky failure flag per check code
//   fail_count                     saturating count of all enabled failures
//   op_count                       saturating count of done rising edges
//   first_fail_valid/code/cycle    capture of the first failure seen
//   busy                           latency window currently open

module ecc_apb_monitor #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int MIN_LAT         = 2,
  parameter int MAX_LAT         = 5,
  parameter int LAT_WIDTH       = 4,
  parameter int CNT_WIDTH       = 16,
  parameter int CYC_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       PENABLE,
  input  logic                       PSEL,
  input  logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic [AMBA_WORD-1:0]       registers_out,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic                       operation_done,
  input  logic [1:0]                 num_of_errors,
  input  logic [DATA_WIDTH-1:0]      gm_data_out,
  input  logic [1:0]                 gm_number_of_errors,
  input  logic [6:0]                 chk_en,
  output logic [6:0]                 err_sticky,
  output logic [CNT_WIDTH-1:0]       fail_count,
  output logic [CNT_WIDTH-1:0]       op_count,
  output logic                       first_fail_valid,
  output logic [2:0]                 first_fail_code,
  output logic [CYC_WIDTH-1:0]       first_fail_cycle,
  output logic                       busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [LAT_WIDTH-1:0] MIN_K = LAT_WIDTH'(MIN_LAT);
  localparam logic [LAT_WIDTH-1:0] MAX_K = LAT_WIDTH'(MAX_LAT);

  logic                 acc;
  logic                 ctrl_wr;
  logic                 done_q;
  logic                 done_rise;
  logic                 post_rst;
  logic [1:0]           mode;
  logic [0:0]           state;
  logic [0:0]           state_next;
  logic [LAT_WIDTH-1:0] lat_cnt;
  logic [LAT_WIDTH-1:0] lat_next;
  logic [LAT_WIDTH-1:0] k;
  logic                 early;
  logic                 timeout;
  logic [6:0]           raw_fail;
  logic [6:0]           fails;
  logic [2:0]           fail_pop;
  logic [2:0]           low_code;
  logic [CNT_WIDTH:0]   fail_sum;
  logic [CYC_WIDTH-1:0] cyc_cnt;
  logic                 unused_bits;

  // Only the low address nibble and the two mode bits of PWDATA matter here.
  assign unused_bits = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PWDATA[AMBA_WORD-1:2]};

  assign acc       = PSEL & PENABLE;
  assign ctrl_wr   = acc & PWRITE & (PADDR[3:0] == 4'd0);
  assign done_rise = operation_done & ~done_q;
  assign k         = lat_cnt + 1'b1;
  assign busy      = (state == ST_WAIT);

  // Latency window. A fresh control write always restarts the count, even
  // mid-window. A done level that is already high when the window opens is
  // only accepted once it falls inside [MIN_LAT, MAX_LAT]. EARLY needs a
  // real rising edge.
  always_comb begin
    state_next = state;
    lat_next   = lat_cnt;
    early      = 1'b0;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl_wr) begin
          state_next = ST_WAIT;
          lat_next   = '0;
        end
      end
      default: begin
        if (ctrl_wr) begin
          lat_next = '0;
        end else if (operation_done && (k >= MIN_K) && (k <= MAX_K)) begin
          state_next = ST_IDLE;
          lat_next   = '0;
        end else if (done_rise && (k < MIN_K)) begin
          early      = 1'b1;
          state_next = ST_IDLE;
          lat_next   = '0;
        end else if (k == MAX_K) begin
          timeout    = 1'b1;
          state_next = ST_IDLE;
          lat_next   = '0;
        end else begin
          lat_next = k;
        end
      end
    endcase
  end

  // Raw per-check failure conditions for the current sampling edge.
  always_comb begin
    raw_fail    = '0;
    raw_fail[0] = post_rst & ((|data_out) | operation_done | (|num_of_errors));
    raw_fail[1] = acc & ~PWRITE & (PRDATA != registers_out);
    raw_fail[2] = early;
    raw_fail[3] = timeout;
    raw_fail[4] = done_rise & (num_of_errors != 2'd2) & (data_out != gm_data_out);
    raw_fail[5] = done_rise & (mode != 2'd0) & (num_of_errors != gm_number_of_errors);
    raw_fail[6] = operation_done & (num_of_errors == 2'd3);
  end

  assign fails = raw_fail & chk_en;

  // Population count of the enabled failures and the lowest failing code.
  // The downward loop leaves the smallest index in low_code.
  always_comb begin
    fail_pop = '0;
    low_code = '0;
    for (int i = 0; i < 7; i++) begin
      fail_pop = fail_pop + {2'b00, fails[i]};
    end
    for (int i = 6; i >= 0; i--) begin
      if (fails[i]) begin
        low_code = 3'(i);
      end
    end
  end

  assign fail_sum = {1'b0, fail_count} + (CNT_WIDTH + 1)'(fail_pop);

  // Control state: FSM, done history, mode register, post-reset marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      lat_cnt  <= '0;
      done_q   <= 1'b0;
      mode     <= 2'd0;
      post_rst <= 1'b1;
      cyc_cnt  <= '0;
    end else begin
      state    <= state_next;
      lat_cnt  <= lat_next;
      done_q   <= operation_done;
      post_rst <= 1'b0;
      cyc_cnt  <= cyc_cnt + 1'b1;
      if (ctrl_wr) begin
        mode <= PWDATA[1:0];
      end
    end
  end

  // Failure bookkeeping. The first-failure capture freezes until the next
  // reset. The stamp is the cycle count of the edge that sampled the fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky       <= '0;
      fail_count       <= '0;
      op_count         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_code  <= '0;
      first_fail_cycle <= '0;
    end else begin
      err_sticky <= err_sticky | fails;
      if (fail_sum[CNT_WIDTH]) begin
        fail_count <= '1;
      end else begin
        fail_count <= fail_sum[CNT_WIDTH-1:0];
      end
      if (done_rise && (op_count != '1)) begin
        op_count <= op_count + 1'b1;
      end
      if (!first_fail_valid && (|fails)) begin
        first_fail_valid <= 1'b1;
        first_fail_code  <= low_code;
        first_fail_cycle <= cyc_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ecc_apb_monitor.sv
// tb_ecc_apb_monitor
//
// Directed bench for ecc_apb_monitor. The monitor is built with a 4-bit
// failure counter so that saturation can be reached in a few cycles. Inputs
// change 1 time unit after a rising edge. Outputs are read at that same
// point, so they show the effect of the edge just taken.

module tb_ecc_apb_monitor;

  localparam int DW  = 32;
  localparam int AW  = 20;
  localparam int WW  = 32;
  localparam int CW  = 4;
  localparam int CYW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] PADDR;
  logic [WW-1:0] PWDATA;
  logic          PENABLE;
  logic          PSEL;
  logic          PWRITE;
  logic [WW-1:0] PRDATA;
  logic [WW-1:0] registers_out;
  logic [DW-1:0] data_out;
  logic          operation_done;
  logic [1:0]    num_of_errors;
  logic [DW-1:0] gm_data_out;
  logic [1:0]    gm_number_of_errors;
  logic [6:0]    chk_en;
  logic [6:0]    err_sticky;
  logic [CW-1:0] fail_count;
  logic [CW-1:0] op_count;
  logic          first_fail_valid;
  logic [2:0]    first_fail_code;
  logic [CYW-1:0] first_fail_cycle;
  logic          busy;

  int assertCount = 0;
  int failCount   = 0;

  ecc_apb_monitor #(
    .DATA_WIDTH(DW), .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(WW),
    .MIN_LAT(2), .MAX_LAT(5), .LAT_WIDTH(4),
    .CNT_WIDTH(CW), .CYC_WIDTH(CYW)
  ) dut (
    .clk(clk), .rst(rst),
    .PADDR(PADDR), .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL),
    .PWRITE(PWRITE), .PRDATA(PRDATA), .registers_out(registers_out),
    .data_out(data_out), .operation_done(operation_done),
    .num_of_errors(num_of_errors), .gm_data_out(gm_data_out),
    .gm_number_of_errors(gm_number_of_errors), .chk_en(chk_en),
    .err_sticky(err_sticky), .fail_count(fail_count), .op_count(op_count),
    .first_fail_valid(first_fail_valid), .first_fail_code(first_fail_code),
    .first_fail_cycle(first_fail_cycle), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the DUT-result side of the monitor inputs.
  task automatic applyStimulus(input logic done, input logic [DW-1:0] dat,
                               input logic [DW-1:0] gm_dat,
                               input logic [1:0] noe, input logic [1:0] gm_noe);
    operation_done      = done;
    data_out            = dat;
    gm_data_out         = gm_dat;
    num_of_errors       = noe;
    gm_number_of_errors = gm_noe;
  endtask

  // Returns just after the release edge.
  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Returns just after the access edge.
  task automatic apbWrite(input logic [AW-1:0] addr, input logic [WW-1:0] wdata);
    PADDR = addr; PWDATA = wdata; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apbRead(input logic [WW-1:0] dut_rd, input logic [WW-1:0] gm_rd);
    PADDR = '0; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    PRDATA = dut_rd; registers_out = gm_rd;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PRDATA = '0; registers_out = '0;
  endtask

  initial begin
    rst = 1'b1;
    PADDR = '0; PWDATA = '0; PENABLE = 1'b0; PSEL = 1'b0; PWRITE = 1'b0;
    PRDATA = '0; registers_out = '0;
    chk_en = 7'h7F;
    applyStimulus(1'b0, '0, '0, 2'd0, 2'd0);
    tick();
    tick();

    // Values held in reset.
    checkOutput("rst_sticky", 32'(err_sticky), 32'h0);
    checkOutput("rst_fail_count", 32'(fail_count), 32'h0);
    checkOutput("rst_op_count", 32'(op_count), 32'h0);
    checkOutput("rst_ff_valid", 32'(first_fail_valid), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);

    // Clean release.
    rst = 1'b0;
    tick();
    checkOutput("clean_release_sticky", 32'(err_sticky), 32'h0);
    checkOutput("clean_release_op_count", 32'(op_count), 32'h0);
    checkOutput("clean_release_fail_count", 32'(fail_count), 32'h0);

    // Release with data_out nonzero on the release edge (cycle 0).
    rst = 1'b1;
    tick();
    applyStimulus(1'b0, 32'h1, '0, 2'd0, 2'd0);
    rst = 1'b0;
    tick();
    checkOutput("rstchk_sticky", 32'(err_sticky), 32'h01);
    checkOutput("rstchk_ff_valid", 32'(first_fail_valid), 32'h1);
    checkOutput("rstchk_ff_code", 32'(first_fail_code), 32'h0);
    checkOutput("rstchk_ff_cycle", first_fail_cycle, 32'h0);
    checkOutput("rstchk_fail_count", 32'(fail_count), 32'h1);
    applyStimulus(1'b0, '0, '0, 2'd0, 2'd0);

    // Good operation: done at k=3 with matching results.
    doReset();
    apbWrite('0, 32'h1);
    checkOutput("op_busy_k0", 32'(busy), 32'h1);
    tick();
    checkOutput("op_busy_k1", 32'(busy), 32'h1);
    tick();
    checkOutput("op_busy_k2", 32'(busy), 32'h1);
    applyStimulus(1'b1, 32'h1234, 32'h1234, 2'd1, 2'd1);
    tick();
    checkOutput("op_busy_done", 32'(busy), 32'h0);
    checkOutput("op_op_count", 32'(op_count), 32'h1);
    checkOutput("op_sticky", 32'(err_sticky), 32'h0);
    checkOutput("op_fail_count", 32'(fail_count), 32'h0);
    applyStimulus(1'b0, '0, '0, 2'd0, 2'd0);
    tick();

    // Timeout: no done, flag appears on the k=5 edge.
    apbWrite('0, 32'h1);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("tmo_busy_k4", 32'(busy), 32'h1);
    checkOutput("tmo_sticky_k4", 32'(err_sticky), 32'h0);
    tick();
    checkOutput("tmo_sticky", 32'(err_sticky), 32'h08);
    checkOutput("tmo_fail_count", 32'(fail_count), 32'h1);
    checkOutput("tmo_busy", 32'(busy), 32'h0);
    checkOutput("tmo_ff_code", 32'(first_fail_code), 32'h3);

    // Early done at k=1.
    apbWrite('0, 32'h1);
    applyStimulus(1'b1, 32'h55, 32'h55, 2'd1, 2'd1);
    tick();
    checkOutput("early_sticky", 32'(err_sticky), 32'h0C);
    checkOutput("early_fail_count", 32'(fail_count), 32'h2);
    checkOutput("early_op_count", 32'(op_count), 32'h2);
    checkOutput("early_busy", 32'(busy), 32'h0);
    checkOutput("early_ff_code_kept", 32'(first_fail_code), 32'h3);
    applyStimulus(1'b0, '0, '0, 2'd0, 2'd0);
    tick();

    // Read-back mismatch.
    apbRead(32'hA5, 32'h5A);
    checkOutput("read_sticky", 32'(err_sticky), 32'h0E);
    checkOutput("read_fail_count", 32'(fail_count), 32'h3);

    // Same read with the READ check masked.
    doReset();
    chk_en = 7'h7D;
    apbRead(32'hA5, 32'h5A);
    checkOutput("read_masked_sticky", 32'(err_sticky), 32'h0);
    checkOutput("read_masked_fail_count", 32'(fail_count), 32'h0);
    checkOutput("read_masked_ff_valid", 32'(first_fail_valid), 32'h0);
    chk_en = 7'h7F;

    // RESULT and BOUND on the same edge.
    doReset();
    applyStimulus(1'b1, 32'h1, 32'h2, 2'd3, 2'd3);
    tick();
    checkOutput("dual_fail_count", 32'(fail_count), 32'h2);
    checkOutput("dual_ff_code", 32'(first_fail_code), 32'h4);
    checkOutput("dual_sticky", 32'(err_sticky), 32'h50);
    checkOutput("dual_op_count", 32'(op_count), 32'h1);
    applyStimulus(1'b0, '0, '0, 2'd0, 2'd0);
    tick();

    // Error-count mismatch with mode 0: ignored.
    applyStimulus(1'b1, 32'h7, 32'h7, 2'd1, 2'd2);
    tick();
    checkOutput("noe_mode0_sticky", 32'(err_sticky), 32'h50);
    checkOutput("noe_mode0_fail_count", 32'(fail_count), 32'h2);
    applyStimulus(1'b0, '0, '0, 2'd0, 2'd0);
    tick();

    // Error-count mismatch with mode 2 inside a valid window.
    apbWrite('0, 32'h2);
    tick();
    tick();
    applyStimulus(1'b1, 32'h7, 32'h7, 2'd1, 2'd2);
    tick();
    checkOutput("noe_mode2_sticky", 32'(err_sticky), 32'h70);
    checkOutput("noe_mode2_fail_count", 32'(fail_count), 32'h3);
    checkOutput("noe_mode2_op_count", 32'(op_count), 32'h3);
    checkOutput("noe_mode2_busy", 32'(busy), 32'h0);
    applyStimulus(1'b0, '0, '0, 2'd0, 2'd0);
    tick();

    // Held mismatching read: one failure per edge, counter saturates at 15.
    PADDR = '0; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    PRDATA = 32'hA5; registers_out = 32'h5A;
    tick();
    PENABLE = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("sat_mid_fail_count", 32'(fail_count), 32'd11);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("sat_fail_count", 32'(fail_count), 32'd15);
    checkOutput("sat_sticky", 32'(err_sticky), 32'h72);
    checkOutput("sat_ff_code_kept", 32'(first_fail_code), 32'h4);
    PSEL = 1'b0; PENABLE = 1'b0; PRDATA = '0; registers_out = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ecc_apb_monitor.md
# ecc_apb_monitor

Synthesizable, parametrised protocol and result monitor for the APB-controlled ECC encoder/decoder. It runs alongside the DUT and the golden model in simulation, emulation or FPGA bring-up. It checks the following:
- reset values
- register read-back
- operation_done latency window
- data and error-count agreement with the golden model
- num_of_errors range

Failures are recorded in sticky flags, a saturating fail counter, and a first-failure capture with a cycle stamp. Each check can be masked at runtime.

## Interface
- DATA_WIDTH, 32, width of data_out / gm_data_out compared.
- AMBA_ADDR_WIDTH, 20, PADDR width.
- AMBA_WORD, 32, PWDATA/PRDATA/registers_out width.
- MIN_LAT, 2, minimum cycles from control write to operation_done (1 <= MIN_LAT <= MAX_LAT).
- MAX_LAT, 5, maximum cycles from control write to operation_done (MAX_LAT < 2^LAT_WIDTH).
- LAT_WIDTH, 4, latency counter width.
- CNT_WIDTH, 16, fail counter and op counter width.
- CYC_WIDTH, 32, cycle stamp width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- PADDR  in  AMBA_ADDR_WIDTH  APB address.
- PWDATA  in  AMBA_WORD  APB write data.
- PENABLE, PSEL, PWRITE  in  1 each  APB controls.
- PRDATA  in  AMBA_WORD  DUT read data.
- registers_out  in  AMBA_WORD  golden-model read data.
- data_out  in  DATA_WIDTH  DUT result.
- operation_done  in  1  DUT done.
- num_of_errors  in  2  DUT error count.
- gm_data_out  in  DATA_WIDTH  golden result.
- gm_number_of_errors  in  2  golden error count.
- chk_en  in  7  per-check enable; bit i enables check code i.
- err_sticky  out  7  sticky fail flag per check code.
- fail_count  out  CNT_WIDTH  saturating total of failures.
- op_count  out  CNT_WIDTH  saturating count of completed operations (done rising edges).
- first_fail_valid  out  1  a failure has been captured.
- first_fail_code  out  3  code of first failure.
- first_fail_cycle  out  CYC_WIDTH  cycle stamp of first failure.
- busy  out  1  latency window open (state WAIT).

## Operation
- Check codes:
  - 0 RST: DUT outputs not zero after reset.
  - 1 READ: read-back mismatch.
  - 2 EARLY: operation_done too early.
  - 3 TIMEOUT: operation_done never arrived.
  - 4 RESULT: data mismatch.
  - 5 NOE: error-count mismatch.
  - 6 BOUND: num_of_errors==3.
- Event definitions:
  - acc = PSEL & PENABLE.
  - ctrl_wr = acc & PWRITE & (PADDR[3:0]==0).
  - done_rise = operation_done & ~done_q, where done_q is operation_done registered.
- RST: post_rst flag is set by reset and cleared on the first clock edge after release. On that edge, data_out, operation_done or num_of_errors nonzero -> fail 0.
- READ: acc & ~PWRITE & (PRDATA != registers_out) -> fail 1.
- mode register: captures PWDATA[1:0] on ctrl_wr. Reset value 0.
- Latency FSM, states IDLE and WAIT. lat_cnt counts cycles since ctrl_wr.
  - IDLE: ctrl_wr -> WAIT, lat_cnt=0.
  - WAIT, each edge: lat_cnt+1 = k.
    - operation_done==1 with MIN_LAT <= k <= MAX_LAT -> IDLE, pass.
    - done_rise with k < MIN_LAT -> fail 2, IDLE.
    - k == MAX_LAT with operation_done==0 -> fail 3, IDLE.
  - ctrl_wr while in WAIT restarts the window (lat_cnt=0), no failure.
- RESULT: done_rise & (num_of_errors != 2) & (data_out != gm_data_out) -> fail 4.
- NOE: done_rise & (mode != 0) & (num_of_errors != gm_number_of_errors) -> fail 5.
- BOUND: operation_done & (num_of_errors == 3) -> fail 6, checked every cycle done is high.
- A failure of code i is counted only if chk_en[i]==1. Disabled checks still advance the FSM.
- Several failures on one edge:
  - err_sticky ORs all of them.
  - fail_count adds their popcount, saturating at all-ones.
  - first-fail capture takes the lowest code.
- First-fail capture is written only while first_fail_valid==0. It is never overwritten until reset.
- op_count increments on done_rise, saturating.
- Cycle counter runs free from 0 after reset and wraps. first_fail_cycle holds the counter value of the sampling edge.

## Timing
- Reset: all outputs are 0, FSM is IDLE, mode=0, cycle counter=0, done_q=0.
- All inputs are sampled on the rising edge of clk. Outputs update on that same edge, so they are visible one cycle after the offending input cycle.
- Reset asserted mid-WAIT aborts the window without a TIMEOUT. post_rst is re-armed.
- busy = (state==WAIT), registered.

## Test plan
- Release reset with DUT outputs zero -> err_sticky=0, op_count=0. Force data_out=0x1 on the release edge -> err_sticky[0]=1, first_fail_code=0, first_fail_cycle=0.
- ctrl_wr of PWDATA=0x1, done rises at k=3 with matching data and errors=1 -> no failure, op_count=1, busy high for cycles k=1..2 (deasserting on the edge where done is sampled at k=3).
- ctrl_wr, done never rises -> at k=5 err_sticky[3]=1 and fail_count=1. Repeat with done at k=1 -> err_sticky[2]=1.
- Read with PRDATA=0xA5, registers_out=0x5A -> err_sticky[1]=1. Same with chk_en[1]=0 -> no flag.
- done_rise with data mismatch and num_of_errors=3 on the same edge -> fail_count +2, first_fail_code=4, err_sticky[4] and err_sticky[6] both set.
- Mode=0 with error-count mismatch -> no NOE failure. Mode=2 with mismatch -> err_sticky[5]=1. 2^CNT_WIDTH+3 failures -> fail_count saturates.
